div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 2, the number of cycles core_init is held high per operation (minimum 1).
REQ-002 SHALL have parameter TIMEOUT, default 63, the maximum number of BUSY cycles allowed before the operation is aborted.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request strobe.
REQ-007 req_ready  out  1  controller is idle and accepts a request.
REQ-008 req_signed  in  1  1 = operands are two's complement; 0 = unsigned.
REQ-009 req_rem  in  1  1 = return remainder; 0 = return quotient.
REQ-010 req_a  in  16  dividend.
REQ-011 req_b  in  16  divisor.
REQ-012 core_init  out  1  start pulse to the unsigned divider core.
REQ-013 core_op_A  out  16  unsigned dividend magnitude sent to the core.
REQ-014 core_op_B  out  16  unsigned divisor magnitude sent to the core.
REQ-015 core_result  in  32  core result, {remainder[31:16], quotient[15:0]}.
REQ-016 core_done  in  1  core completion flag.
REQ-017 rsp_valid  out  1  response available.
REQ-018 rsp_ready  in  1  consumer accepts the response.
REQ-019 rsp_data  out  16  selected quotient or remainder.
REQ-020 rsp_dbz  out  1  set when the divisor was zero.
REQ-021 rsp_err  out  1  set when the core timed out.

Function
REQ-022 FSM SHALL have exactly four states: IDLE, INIT, BUSY, RSP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1, latching req_a, req_b, req_signed and req_rem.
REQ-024 On accept with req_b==0, the FSM SHALL go IDLE->RSP with quotient 16'hFFFF, remainder req_a and rsp_dbz=1, and SHALL NOT assert core_init.
REQ-025 On accept with req_signed=1, req_a==16'h8000 and req_b==16'hFFFF, the FSM SHALL go IDLE->RSP with quotient 16'h8000, remainder 0 and no core_init.
REQ-026 For all other accepted requests, the FSM SHALL go IDLE->INIT, with core_op_A/core_op_B = |a|,|b| when req_signed=1 and raw values otherwise.
REQ-027 core_op_A and core_op_B SHALL be stable from INIT entry until BUSY exit.
REQ-028 In INIT, core_init SHALL be 1 for exactly INIT_CYCLES cycles, then the FSM SHALL go to BUSY; core_init SHALL be 0 in every other state.
REQ-029 core_done SHALL be ignored outside BUSY.
REQ-030 In BUSY, on core_done=1 the controller SHALL capture core_result and go to RSP.
REQ-031 Signed fix-up: quotient SHALL be negated when the operand signs differ; remainder SHALL take the dividend's sign; all arithmetic is mod 2^16.
REQ-032 A BUSY cycle counter SHALL force BUSY->RSP with rsp_err=1 and rsp_data=0 when TIMEOUT cycles elapse without core_done.
REQ-033 core_done arriving on the same cycle as the timeout SHALL win, giving rsp_err=0.
REQ-034 In RSP, rsp_valid=1 and rsp_data/rsp_dbz/rsp_err SHALL be held stable until rsp_ready=1, then the FSM SHALL go to IDLE.
REQ-035 rsp_valid SHALL clear on the cycle after the handshake.
REQ-036 Latency for special cases (REQ-024, REQ-025): rsp_valid SHALL rise 1 cycle after accept.
REQ-037 Latency for normal cases: rsp_valid SHALL rise 1 cycle after the edge that samples core_done.
REQ-038 No new request SHALL be accepted before the response handshake completes.

Reset
REQ-039 reset=0 SHALL immediately force state IDLE, core_init=0, rsp_valid=0, rsp_data=0, rsp_dbz=0, rsp_err=0, core_op_A=0, core_op_B=0 and counters=0.
REQ-040 During reset=0, req_ready SHALL be 0.
REQ-041 From the first edge after reset=1, req_ready SHALL be 1.
REQ-042 Reset in INIT/BUSY/RSP SHALL abort the operation, drop any pending response, and leave no residual core_init.

Verification
REQ-043 Unsigned: a=C86C, b=00CA, rem=0; core returns {0000,00FE} -> rsp_data=00FE, dbz=0, err=0; repeated with rem=1 -> rsp_data=0000.
REQ-044 Signed: a=FFF9, b=0002 -> core sees 0007/0002; core returns {0001,0003} -> quotient FFFD, remainder FFFF.
REQ-045 Divide-by-zero: a=1234, b=0000 -> rsp_valid 1 cycle after accept, quotient FFFF, remainder 1234, dbz=1, core_init never high.
REQ-046 Overflow: signed a=8000, b=FFFF -> quotient 8000, remainder 0000, core_init never high.
REQ-047 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_data stable, req_ready 0 throughout; handshake on cycle 6 -> IDLE on the next cycle.
REQ-048 Fault handling: core_done held 0 -> rsp_err=1 after 63 BUSY cycles; separately, reset pulsed mid-BUSY -> all outputs 0 at once, next request processed normally.

Source files
------------

// File: rtl/div_ctrl.sv
`timescale 1ns/1ps
// Sequencing controller around an unsigned 16-bit divider core: handles sign fix-up,
// divide-by-zero and signed overflow short-cuts, core timeout and a valid/ready response.
module div_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_rem,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        core_init,
  output logic [15:0] core_op_A,
  output logic [15:0] core_op_B,
  input  logic [31:0] core_result,
  input  logic        core_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_dbz,
  output logic        rsp_err
);

  localparam int unsigned CntMax = (TIMEOUT > INIT_CYCLES) ? TIMEOUT : INIT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StInit, StBusy, StRsp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [15:0]       data_q, data_d;
  logic              dbz_q, dbz_d, err_q, err_d;
  logic              rem_q, rem_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic              live_q;

  logic              accept;
  logic [15:0]       a_mag, b_mag, q_raw, r_raw, q_fix, r_fix;

  // live_q keeps req_ready low until the first edge after reset release
  assign req_ready = (state_q == StIdle) && live_q;
  assign core_init = (state_q == StInit);
  assign rsp_valid = (state_q == StRsp);
  assign core_op_A = op_a_q;
  assign core_op_B = op_b_q;
  assign rsp_data  = data_q;
  assign rsp_dbz   = dbz_q;
  assign rsp_err   = err_q;

  assign accept = req_valid && req_ready;
  assign a_mag  = (req_signed && req_a[15]) ? (~req_a + 16'd1) : req_a;
  assign b_mag  = (req_signed && req_b[15]) ? (~req_b + 16'd1) : req_b;
  assign q_raw  = core_result[15:0];
  assign r_raw  = core_result[31:16];
  assign q_fix  = neg_q_q ? (~q_raw + 16'd1) : q_raw;
  assign r_fix  = neg_r_q ? (~r_raw + 16'd1) : r_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    data_d  = data_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    rem_d   = rem_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rem_d   = req_rem;
          neg_q_d = req_signed && (req_a[15] ^ req_b[15]);
          neg_r_d = req_signed && req_a[15];
          cnt_d   = '0;
          err_d   = 1'b0;
          dbz_d   = 1'b0;
          if (req_b == 16'h0000) begin
            state_d = StRsp;
            dbz_d   = 1'b1;
            data_d  = req_rem ? req_a : 16'hFFFF;
          end else if (req_signed && req_a == 16'h8000 && req_b == 16'hFFFF) begin
            // -32768 / -1 does not fit; answer directly without the core
            state_d = StRsp;
            data_d  = req_rem ? 16'h0000 : 16'h8000;
          end else begin
            state_d = StInit;
            op_a_d  = a_mag;
            op_b_d  = b_mag;
          end
        end
      end
      StInit: begin
        if (cnt_q == CntW'(INIT_CYCLES - 1)) begin
          state_d = StBusy;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy: begin
        if (core_done) begin
          state_d = StRsp;
          data_d  = rem_q ? r_fix : q_fix;
          err_d   = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StRsp;
          data_d  = 16'h0000;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      data_q  <= '0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      data_q  <= data_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for div_ctrl: the stimulus task plays the divider core and queues the
// expected response; a negedge monitor checks every response cycle against the queue head.
module tb_div_ctrl;

  localparam int unsigned InitCycles = 2;
  localparam int unsigned Timeout    = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_signed = 1'b0, req_rem = 1'b0;
  logic [15:0] req_a = '0, req_b = '0;
  logic        req_ready, core_init, rsp_valid, rsp_dbz, rsp_err;
  logic [15:0] core_op_A, core_op_B, rsp_data;
  logic [31:0] core_result = '0;
  logic        core_done = 1'b0, rsp_ready = 1'b0;

  div_ctrl #(.INIT_CYCLES(InitCycles), .TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_rem(req_rem), .req_a(req_a), .req_b(req_b),
    .core_init(core_init), .core_op_A(core_op_A), .core_op_B(core_op_B),
    .core_result(core_result), .core_done(core_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        dbz;
    logic        err;
    int          rise;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   init_hi = 0;
  bit   in_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_init) init_hi <= init_hi + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: compares each valid cycle with the queue head, pops when valid drops
  always @(negedge clk) begin
    if (!reset) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_dbz", 32'(rsp_dbz), 32'(exp_q[0].dbz));
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        chk("req_ready_in_rsp", 32'(req_ready), 32'd0);
        if (!in_rsp) chk("rsp_latency", 32'(cyc), 32'(exp_q[0].rise));
        in_rsp = 1'b1;
      end
    end else if (in_rsp) begin
      void'(exp_q.pop_front());
      in_rsp = 1'b0;
    end
  end

  // d = BUSY cycle on which the core reports done (0 = never); hold = cycles of backpressure
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                        input logic rem, input logic [31:0] res, input int d, input int hold,
                        input logic early, input logic special, input logic [15:0] e_opa,
                        input logic [15:0] e_opb, input logic [15:0] e_data,
                        input logic e_dbz, input logic e_err);
    int   acc;
    int   ic0;
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      chk("wait_idle", 32'(req_ready), 32'd1);
      return;
    end
    req_a = a; req_b = b; req_signed = sgn; req_rem = rem; req_valid = 1'b1;
    ic0 = init_hi;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    e.data = e_data; e.dbz = e_dbz; e.err = e_err;
    if (special)     e.rise = acc;
    else if (d == 0) e.rise = acc + InitCycles + Timeout;
    else             e.rise = acc + InitCycles + d;
    exp_q.push_back(e);
    if (!special) begin
      @(negedge clk);
      chk("core_op_A", 32'(core_op_A), 32'(e_opa));
      chk("core_op_B", 32'(core_op_B), 32'(e_opb));
      if (early) begin
        // spurious done while in INIT must be ignored
        core_result = 32'hDEAD_BEEF;
        core_done = 1'b1;
        repeat (InitCycles - 1) @(posedge clk);
        #1 core_done = 1'b0;
      end
      if (d > 0) begin
        while (cyc < acc + InitCycles + d - 1) begin
          @(posedge clk); #1;
        end
        core_result = res;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      exp_q.delete();
      return;
    end
    #1;
    repeat (hold) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("idle_after_hs", 32'(req_ready), 32'd1);
    chk("init_cycles", 32'(init_hi - ic0), special ? 32'd0 : 32'(InitCycles));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", {core_init, rsp_valid, rsp_dbz, rsp_err, rsp_data, 12'd0}, 32'd0);
    chk("rst_ops", {core_op_A, core_op_B}, 32'd0);
    #2 reset = 1'b1;
    #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(req_ready), 32'd1);

    //     a        b        sgn   rem   core_result   d  hold early spec  opA      opB      data     dbz   err
    run_op(16'hC86C, 16'h00CA, 1'b0, 1'b0, 32'h0000_00FE, 3, 0, 1'b0, 1'b0, 16'hC86C, 16'h00CA, 16'h00FE, 1'b0, 1'b0);
    run_op(16'hC86C, 16'h00CA, 1'b0, 1'b1, 32'h0000_00FE, 1, 0, 1'b0, 1'b0, 16'hC86C, 16'h00CA, 16'h0000, 1'b0, 1'b0);
    run_op(16'hFFF9, 16'h0002, 1'b1, 1'b0, 32'h0001_0003, 2, 0, 1'b0, 1'b0, 16'h0007, 16'h0002, 16'hFFFD, 1'b0, 1'b0);
    run_op(16'hFFF9, 16'h0002, 1'b1, 1'b1, 32'h0001_0003, 2, 1, 1'b0, 1'b0, 16'h0007, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
    run_op(16'h1234, 16'h0000, 1'b0, 1'b0, 32'h0,         0, 0, 1'b0, 1'b1, 16'h0,    16'h0,    16'hFFFF, 1'b1, 1'b0);
    run_op(16'h1234, 16'h0000, 1'b0, 1'b1, 32'h0,         0, 2, 1'b0, 1'b1, 16'h0,    16'h0,    16'h1234, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, 32'h0,         0, 0, 1'b0, 1'b1, 16'h0,    16'h0,    16'hFFFF, 1'b1, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b1, 1'b0, 32'h0,         0, 0, 1'b0, 1'b1, 16'h0,    16'h0,    16'h8000, 1'b0, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b1, 1'b1, 32'h0,         0, 0, 1'b0, 1'b1, 16'h0,    16'h0,    16'h0000, 1'b0, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 1'b1, 32'h8000_0000, 4, 0, 1'b0, 1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b0);
    run_op(16'h0064, 16'hFFF9, 1'b1, 1'b0, 32'h0002_000E, 5, 5, 1'b0, 1'b0, 16'h0064, 16'h0007, 16'hFFF2, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0003, 1'b1, 1'b1, 32'h0002_2AAA, 2, 0, 1'b1, 1'b0, 16'h8000, 16'h0003, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0003, 1'b1, 1'b0, 32'h0002_2AAA, 1, 0, 1'b1, 1'b0, 16'h8000, 16'h0003, 16'hD556, 1'b0, 1'b0);
    run_op(16'h0010, 16'h0003, 1'b0, 1'b0, 32'h0,         0, 1, 1'b0, 1'b0, 16'h0010, 16'h0003, 16'h0000, 1'b0, 1'b1);
    run_op(16'h0010, 16'h0003, 1'b0, 1'b0, 32'h0001_0005, Timeout, 0, 1'b0, 1'b0, 16'h0010, 16'h0003, 16'h0005, 1'b0, 1'b0);

    // Reset pulsed in BUSY: everything clears at once and the next request works normally
    @(negedge clk);
    req_a = 16'h00FF; req_b = 16'h0010; req_signed = 1'b0; req_rem = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (InitCycles + 3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_outputs", {core_init, rsp_valid, rsp_dbz, rsp_err, rsp_data, 12'd0}, 32'd0);
    chk("mid_rst_ops", {core_op_A, core_op_B}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("mid_rst_ready_held", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    run_op(16'h00FF, 16'h0010, 1'b0, 1'b1, 32'h000F_000F, 2, 0, 1'b0, 1'b0, 16'h00FF, 16'h0010, 16'h000F, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
